serial_port_sequencer: RTL and testbench

SERIAL_PORT_SEQUENCER -- requirements
Module: serial_port_sequencer

---
 rtl/serial_port_sequencer_pkg.sv | 17 +
 rtl/frame_bit_counter.sv | 30 +++
 rtl/serial_port_sequencer.sv | 138 +++++++++++++
 tb/tb_serial_port_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_port_sequencer_pkg.sv
// Shared types and constants for the serial port sequencer.
// Frame: start(0), 2 port bits, LEN_W length bits, N data bits, MSB first.
package serial_port_sequencer_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int NPORTS    = 4;
  localparam int PORT_W    = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PORT = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/frame_bit_counter.sv
// Loadable down-counter qualified by the bit tick.
// Shared by header bit counting and data remaining count.
module frame_bit_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // Saturates at zero so a stray decrement never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (load)
        count <= load_val;
      else if (dec && !zero)
        count <= count - W'(1);
    end
  end

endmodule

// File: rtl/serial_port_sequencer.sv
// Decodes serial frames and routes data bits to one of four ports.
// busy and done are registered; valid, dout and sh_en are combinational.
module serial_port_sequencer
  import serial_port_sequencer_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int PORTS = NPORTS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clkEN,
  input  logic             SerIn,
  output logic             sh_en,
  output logic [1:0]       port_q,
  output logic             busy,
  output logic [PORTS-1:0] valid,
  output logic [PORTS-1:0] dout,
  output logic             done
);

  state_t state, state_n;

  logic [PORT_W-1:0] port_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  len_n;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              cnt_last;
  logic              cnt_load;
  logic              cnt_dec;
  logic              done_r;
  logic              busy_r;

  assign port_q   = port_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign len_n    = {len_r[LEN_W-2:0], SerIn};
  assign cnt_last = (cnt == LEN_W'(1));

  frame_bit_counter #(
    .W(LEN_W)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .en      (clkEN),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(cnt_val),
    .count   (cnt),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= (state_n == S_DONE);
      busy_r <= (state_n != S_IDLE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      port_r <= '0;
      len_r  <= '0;
    end else if (clkEN) begin
      if (state == S_PORT)
        port_r <= {port_r[0], SerIn};
      if (state == S_LEN)
        len_r <= len_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (clkEN && !SerIn)
          state_n = S_PORT;
      S_PORT:
        if (clkEN && cnt_last)
          state_n = S_LEN;
      S_LEN:
        if (clkEN && cnt_last)
          state_n = (len_n == '0) ? S_DONE : S_DATA;
      S_DATA:
        if (clkEN && (cnt_last || cnt_zero))
          state_n = S_DONE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    sh_en    = 1'b0;
    valid    = '0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state)
      S_IDLE: begin
        cnt_load = !SerIn;
        cnt_val  = LEN_W'(PORT_W);
      end
      S_PORT: begin
        sh_en = clkEN;
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = LEN_W'(LEN_W);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_LEN: begin
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = len_n;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DATA: begin
        valid[port_r] = 1'b1;
        cnt_dec       = 1'b1;
      end
      default: ;
    endcase
  end

  assign dout = valid & {PORTS{SerIn}};

endmodule

// File: tb/tb_serial_port_sequencer.sv
// Directed bench for serial_port_sequencer.
// Inputs change 1ns after posedge; monitor samples on negedge.
module tb_serial_port_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       clkEN;
  logic       SerIn;
  logic       sh_en;
  logic [1:0] port_q;
  logic       busy;
  logic [3:0] valid;
  logic [3:0] dout;
  logic       done;

  serial_port_sequencer dut (
    .clock (clock),
    .reset (reset),
    .clkEN (clkEN),
    .SerIn (SerIn),
    .sh_en (sh_en),
    .port_q(port_q),
    .busy  (busy),
    .valid (valid),
    .dout  (dout),
    .done  (done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int period = 1;

  int n_sh = 0, n_val = 0, n_done = 0, n_busy = 0;
  int tp0 = 0, tp1 = 0, tp2 = 0, tp3 = 0;
  logic [63:0] dbits = '0;

  int s_sh, s_val, s_done, s_busy, s_tp0, s_tp1, s_tp2, s_tp3;

  always @(negedge clock) begin
    if (!reset) begin
      if (sh_en) n_sh++;
      if (valid != 4'b0) n_val++;
      if (done) n_done++;
      if (busy) n_busy++;
      if (clkEN && valid != 4'b0) begin
        dbits = {dbits[62:0], |dout};
        if (valid[0]) tp0++;
        if (valid[1]) tp1++;
        if (valid[2]) tp2++;
        if (valid[3]) tp3++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_sh = n_sh; s_val = n_val; s_done = n_done; s_busy = n_busy;
    s_tp0 = tp0; s_tp1 = tp1; s_tp2 = tp2; s_tp3 = tp3;
  endtask

  task automatic drive(input logic en, input logic b);
    clkEN = en;
    SerIn = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    repeat (period - 1) drive(1'b0, b);
    drive(1'b1, b);
  endtask

  task automatic send_bits(input logic [15:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input string tag, input logic [1:0] p,
                            input int n, input logic [15:0] d);
    send_bit(1'b0);
    send_bits(16'(p), 2);
    send_bits(16'(n), 4);
    send_bits(d, n);
    check({tag, "_done_hi"}, 64'(done), 64'd1);
    drive(1'b1, 1'b1);
    check({tag, "_done_lo"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    clkEN = 1'b0;
    SerIn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_sh_en", 64'(sh_en), 64'd0);
    check("rst_port_q", 64'(port_q), 64'd0);
    reset = 1'b0;
    repeat (3) drive(1'b1, 1'b1);

    // port 2, N=3, data 101, tick every cycle
    period = 1;
    snap();
    send_frame("t1", 2'd2, 3, 16'b101);
    check("t1_port_q", 64'(port_q), 64'd2);
    check("t1_valid_cyc", 64'(n_val - s_val), 64'd3);
    check("t1_p2_ticks", 64'(tp2 - s_tp2), 64'd3);
    check("t1_data", dbits & 64'h7, 64'b101);
    check("t1_ndone", 64'(n_done - s_done), 64'd1);
    check("t1_sh_en", 64'(n_sh - s_sh), 64'd2);

    // same frame, tick every 3rd cycle
    period = 3;
    snap();
    send_frame("t2", 2'd2, 3, 16'b101);
    check("t2_port_q", 64'(port_q), 64'd2);
    check("t2_valid_cyc", 64'(n_val - s_val), 64'd9);
    check("t2_p2_ticks", 64'(tp2 - s_tp2), 64'd3);
    check("t2_data", dbits & 64'h7, 64'b101);
    check("t2_ndone", 64'(n_done - s_done), 64'd1);
    check("t2_sh_en", 64'(n_sh - s_sh), 64'd2);

    // port 3, N=0
    period = 1;
    snap();
    send_frame("t3", 2'd3, 0, 16'd0);
    check("t3_port_q", 64'(port_q), 64'd3);
    check("t3_valid_cyc", 64'(n_val - s_val), 64'd0);
    check("t3_ndone", 64'(n_done - s_done), 64'd1);

    // reset during 2nd data bit of an N=5 frame
    send_bit(1'b0);
    send_bits(16'd1, 2);
    send_bits(16'd5, 4);
    send_bit(1'b1);
    clkEN = 1'b1;
    SerIn = 1'b0;
    #1;
    check("t4_valid_pre", 64'(valid), 64'b0010);
    reset = 1'b1;
    #1;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_valid", 64'(valid), 64'd0);
    check("t4_dout", 64'(dout), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    check("t4_sh_en", 64'(sh_en), 64'd0);
    check("t4_port_q", 64'(port_q), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    snap();
    repeat (6) drive(1'b1, 1'b1);
    check("t4_no_done", 64'(n_done - s_done), 64'd0);
    check("t4_idle_busy", 64'(n_busy - s_busy), 64'd0);
    snap();
    send_frame("t4b", 2'd2, 3, 16'b110);
    check("t4b_port_q", 64'(port_q), 64'd2);
    check("t4b_data", dbits & 64'h7, 64'b110);
    check("t4b_p2_ticks", 64'(tp2 - s_tp2), 64'd3);

    // back-to-back frames
    snap();
    send_frame("t5a", 2'd1, 2, 16'b10);
    send_frame("t5b", 2'd3, 15, 16'h4B3A);
    check("t5_p1_ticks", 64'(tp1 - s_tp1), 64'd2);
    check("t5_p3_ticks", 64'(tp3 - s_tp3), 64'd15);
    check("t5_ndone", 64'(n_done - s_done), 64'd2);
    check("t5_data", dbits & 64'h1FFFF, {47'd0, 2'b10, 15'h4B3A});
    check("t5_port_q", 64'(port_q), 64'd3);

    // idle line
    snap();
    repeat (100) drive(1'b1, 1'b1);
    check("t6_busy_cyc", 64'(n_busy - s_busy), 64'd0);
    check("t6_sh_en", 64'(n_sh - s_sh), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_port_q", 64'(port_q), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
